// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared types and constants for the Morse receiver
//
// Purpose: state encoding, ASCII constants and symbol values shared by the
// decoder, its lookup table and the future encoder block.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,  // no character in progress
    MARK,  // key down, timing the mark
    GAP,   // key up inside a character, timing the gap
    HOLD   // stuck key reported, waiting for release
  } state_t;

  localparam logic [7:0] SPACE   = 8'h20;
  localparam logic [7:0] UNKNOWN = 8'h3F;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/morse_lut.sv
// rtl/morse_lut.sv - combinational Morse code to ASCII lookup
//
// Purpose: maps a (len, pattern) pair to ITU letters A-Z and digits 0-9.
// Symbols are packed MSB-first into the low len bits of pattern
// (dot = 0, dash = 1), so the last symbol received sits in bit 0.
// Ports:
//   len     in   number of valid symbols in pattern
//   pattern in   symbol bits, unused upper bits are zero
//   ascii   out  decoded character, UNKNOWN when not mapped
//   hit     out  1 when (len, pattern) is a defined code
module morse_lut
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = 5,
  parameter int LEN_W       = 3
) (
  input  logic [LEN_W-1:0]       len,
  input  logic [MAX_SYMBOLS-1:0] pattern,
  output logic [7:0]             ascii,
  output logic                   hit
);

  logic [7:0] code;
  logic [7:0] val;
  logic       short_code;

  // No ITU character is longer than five symbols, so only the low five
  // pattern bits and the low three length bits can ever select an entry.
  assign short_code = (len <= LEN_W'(5));
  assign code       = {len[2:0], pattern[4:0]};

  always_comb begin
    val = UNKNOWN;
    case (code)
      8'b010_00001: val = 8'h41; // A .-
      8'b100_01000: val = 8'h42; // B -...
      8'b100_01010: val = 8'h43; // C -.-.
      8'b011_00100: val = 8'h44; // D -..
      8'b001_00000: val = 8'h45; // E .
      8'b100_00010: val = 8'h46; // F ..-.
      8'b011_00110: val = 8'h47; // G --.
      8'b100_00000: val = 8'h48; // H ....
      8'b010_00000: val = 8'h49; // I ..
      8'b100_00111: val = 8'h4A; // J .---
      8'b011_00101: val = 8'h4B; // K -.-
      8'b100_00100: val = 8'h4C; // L .-..
      8'b010_00011: val = 8'h4D; // M --
      8'b010_00010: val = 8'h4E; // N -.
      8'b011_00111: val = 8'h4F; // O ---
      8'b100_00110: val = 8'h50; // P .--.
      8'b100_01101: val = 8'h51; // Q --.-
      8'b011_00010: val = 8'h52; // R .-.
      8'b011_00000: val = 8'h53; // S ...
      8'b001_00001: val = 8'h54; // T -
      8'b011_00001: val = 8'h55; // U ..-
      8'b100_00001: val = 8'h56; // V ...-
      8'b011_00011: val = 8'h57; // W .--
      8'b100_01001: val = 8'h58; // X -..-
      8'b100_01011: val = 8'h59; // Y -.--
      8'b100_01100: val = 8'h5A; // Z --..
      8'b101_11111: val = 8'h30; // 0 -----
      8'b101_01111: val = 8'h31; // 1 .----
      8'b101_00111: val = 8'h32; // 2 ..---
      8'b101_00011: val = 8'h33; // 3 ...--
      8'b101_00001: val = 8'h34; // 4 ....-
      8'b101_00000: val = 8'h35; // 5 .....
      8'b101_10000: val = 8'h36; // 6 -....
      8'b101_11000: val = 8'h37; // 7 --...
      8'b101_11100: val = 8'h38; // 8 ---..
      8'b101_11110: val = 8'h39; // 9 ----.
      default:      val = UNKNOWN;
    endcase
  end

  assign hit   = short_code && (val != UNKNOWN);
  assign ascii = hit ? val : UNKNOWN;

endmodule

// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - timed Morse receiver producing ASCII characters
//
// Purpose: classifies marks as dot/dash by duration, closes a character after
// a letter gap, emits a space after a word gap and flags bad codes and stuck
// keys.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   key_in     in   1 = key down; already synchronised and debounced
//   char_out   out  last decoded ASCII character, held between pulses
//   char_valid out  one-cycle pulse, char_out is new
//   error      out  one-cycle pulse; with char_valid on a bad code, alone on
//                   a stuck key
module morse_decoder
  import morse_pkg::*;
#(
  parameter int DOT_MAX      = 4,
  parameter int LETTER_GAP   = 8,
  parameter int WORD_GAP     = 20,
  parameter int MARK_TIMEOUT = 32,
  parameter int MAX_SYMBOLS  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_in,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       error
);

  localparam int CNT_W = $clog2(max_int(WORD_GAP, MARK_TIMEOUT)) + 1;
  localparam int LEN_W = $clog2(MAX_SYMBOLS + 1);

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next, cnt_inc;
  logic [MAX_SYMBOLS-1:0] pattern, pattern_next;
  logic [LEN_W-1:0]       len, len_next;
  logic                   overflow, overflow_next;
  logic                   space_armed, space_armed_next;
  logic [7:0]             char_out_next;
  logic                   char_valid_next, error_next;
  logic                   sym;
  logic [7:0]             lut_ascii;
  logic                   lut_hit;

  morse_lut #(
    .MAX_SYMBOLS (MAX_SYMBOLS),
    .LEN_W       (LEN_W)
  ) u_lut (
    .len     (len),
    .pattern (pattern),
    .ascii   (lut_ascii),
    .hit     (lut_hit)
  );

  // Saturating so a long idle period can never wrap back onto WORD_GAP and
  // produce a second space.
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  assign sym     = (cnt < CNT_W'(DOT_MAX)) ? DOT : DASH;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pattern     <= '0;
      len         <= '0;
      overflow    <= 1'b0;
      space_armed <= 1'b0;
      char_out    <= 8'h00;
      char_valid  <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      pattern     <= pattern_next;
      len         <= len_next;
      overflow    <= overflow_next;
      space_armed <= space_armed_next;
      char_out    <= char_out_next;
      char_valid  <= char_valid_next;
      error       <= error_next;
    end
  end

  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    pattern_next     = pattern;
    len_next         = len;
    overflow_next    = overflow;
    space_armed_next = space_armed;
    char_out_next    = char_out;
    char_valid_next  = 1'b0;
    error_next       = 1'b0;

    case (state)
      IDLE: begin
        if (key_in) begin
          state_next = MARK;
          cnt_next   = CNT_W'(1);
        end else begin
          // The count here continues from the gap that closed the last
          // character, so the word gap is measured from the last mark.
          cnt_next = cnt_inc;
          if (space_armed && (cnt_inc == CNT_W'(WORD_GAP))) begin
            char_out_next    = SPACE;
            char_valid_next  = 1'b1;
            space_armed_next = 1'b0;
          end
        end
      end

      MARK: begin
        if (key_in) begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_W'(MARK_TIMEOUT)) begin
            error_next    = 1'b1;
            pattern_next  = '0;
            len_next      = '0;
            overflow_next = 1'b0;
            state_next    = HOLD;
          end
        end else begin
          if (len == LEN_W'(MAX_SYMBOLS)) begin
            overflow_next = 1'b1;
          end else begin
            pattern_next = {pattern[MAX_SYMBOLS-2:0], sym};
            len_next     = len + LEN_W'(1);
          end
          state_next = GAP;
          cnt_next   = CNT_W'(1);
        end
      end

      GAP: begin
        if (key_in) begin
          state_next = MARK;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_W'(LETTER_GAP)) begin
            char_valid_next = 1'b1;
            if (lut_hit && !overflow) begin
              char_out_next = lut_ascii;
            end else begin
              char_out_next = UNKNOWN;
              error_next    = 1'b1;
            end
            pattern_next     = '0;
            len_next         = '0;
            overflow_next    = 1'b0;
            space_armed_next = 1'b1;
            state_next       = IDLE;
          end
        end
      end

      HOLD: begin
        if (!key_in) begin
          state_next = IDLE;
          cnt_next   = CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_morse_decoder.sv
// tb/tb_morse_decoder.sv - randomized self-checking bench for morse_decoder
module tb_morse_decoder;

  localparam int DOT_MAX      = 4;
  localparam int LETTER_GAP   = 8;
  localparam int WORD_GAP     = 20;
  localparam int MARK_TIMEOUT = 32;
  localparam int MAX_SYMBOLS  = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_in = 1'b0;
  logic [7:0] char_out;
  logic       char_valid;
  logic       error;

  morse_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .char_out   (char_out),
    .char_valid (char_valid),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int idx     = 0;
  logic [7:0] held = 8'h00;
  bit armed = 1'b0;
  // Expected events keyed by sample index: {valid, err, char}.
  // valid=0,err=1 marks a stuck-key error (char_out unchanged).
  logic [9:0] ev[int];

  string codes[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                       "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                       "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                       "-.--", "--..", "-----", ".----", "..---", "...--",
                       "....-", ".....", "-....", "--...", "---..", "----."};
  string alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] decode(input string code);
    if (code.len() > MAX_SYMBOLS) return {1'b1, 8'h3F};
    for (int i = 0; i < 36; i++)
      if (codes[i] == code) return {1'b0, alpha[i]};
    return {1'b1, 8'h3F};
  endfunction

  task automatic step(input logic k);
    logic [9:0]  e;
    logic [31:0] exp;
    key_in = k;
    @(posedge clk);
    #1;
    idx++;
    if (reset) begin
      held = 8'h00;
      exp  = 32'd0;
    end else if (ev.exists(idx)) begin
      e = ev[idx];
      ev.delete(idx);
      if (e[9]) begin
        held = e[7:0];
        exp  = {22'd0, e};
      end else begin
        exp = {22'd0, 2'b01, held};
      end
    end else begin
      exp = {22'd0, 2'b00, held};
    end
    check_val($sformatf("out@%0d", idx), {22'd0, char_valid, error, char_out}, exp);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) step(1'b0);
    reset = 1'b0;
    armed = 1'b0;
    ev.delete();
  endtask

  // Sends one character; lengths of 0 mean "pick at random".
  task automatic send_code(input string code, input int gap, input int dot_len,
                           input int dash_len, input int sgap);
    int L;
    int g;
    int first_low;
    byte c;
    for (int i = 0; i < code.len(); i++) begin
      c = code[i];
      if (c == 8'h2D) L = (dash_len > 0) ? dash_len : int'($urandom_range(12, DOT_MAX));
      else            L = (dot_len > 0) ? dot_len : int'($urandom_range(DOT_MAX - 1, 1));
      repeat (L) step(1'b1);
      if (i != code.len() - 1) begin
        g = (sgap > 0) ? sgap : int'($urandom_range(LETTER_GAP - 1, 1));
        repeat (g) step(1'b0);
      end
    end
    first_low = idx + 1;
    ev[first_low + LETTER_GAP - 1] = {1'b1, decode(code)};
    armed = 1'b1;
    if (gap >= WORD_GAP) begin
      ev[first_low + WORD_GAP - 1] = {2'b10, 8'h20};
      armed = 1'b0;
    end
    repeat (gap) step(1'b0);
  endtask

  task automatic send_stuck(input int L, input int gap);
    int first_low;
    ev[idx + MARK_TIMEOUT] = {2'b01, 8'h00};
    repeat (L) step(1'b1);
    first_low = idx + 1;
    if (armed && gap >= WORD_GAP) begin
      ev[first_low + WORD_GAP - 1] = {2'b10, 8'h20};
      armed = 1'b0;
    end
    repeat (gap) step(1'b0);
  endtask

  function automatic int rand_gap();
    if ($urandom_range(3, 0) == 0) return int'($urandom_range(30, WORD_GAP));
    return int'($urandom_range(WORD_GAP - 1, LETTER_GAP));
  endfunction

  initial begin
    string s;
    int r;
    int n;

    apply_reset(3);

    send_code(".", 8, 2, 0, 0);            // E
    send_code("-.-.", 8, 2, 6, 2);         // C
    send_code("-.-.", 8, 3, 4, 2);         // C at dot/dash boundary
    send_code("-----", 70, 0, 6, 0);       // 0, one space, then silence
    send_code("......", 8, 0, 0, 0);       // overflow
    send_code("..--", 8, 0, 0, 0);         // unmapped
    send_code("-", 8, 0, MARK_TIMEOUT - 1, 0); // longest legal dash
    send_stuck(MARK_TIMEOUT, 3);
    send_code(".", 8, 2, 0, 0);            // E after stuck key
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    apply_reset(1);                        // partial character discarded
    send_code("-", 25, 0, 6, 0);           // T, no leading space

    repeat (60) begin
      r = int'($urandom_range(9, 0));
      if (r == 0) begin
        send_stuck(int'($urandom_range(40, MARK_TIMEOUT)), int'($urandom_range(25, 1)));
      end else if (r == 1) begin
        s = "";
        n = int'($urandom_range(6, 1));
        for (int i = 0; i < n; i++) s = {s, ($urandom_range(1, 0) == 1) ? "-" : "."};
        send_code(s, rand_gap(), 0, 0, 0);
      end else begin
        send_code(codes[$urandom_range(35, 0)], rand_gap(), 0,
                  ($urandom_range(7, 0) == 0) ? MARK_TIMEOUT - 1 : 0, 0);
      end
    end

    check_val("pending", ev.num(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
Timed Morse receiver. It samples a single key line, classifies each mark as dot or dash by its duration, and groups symbols into characters by gap length. It emits ASCII for A–Z and 0–9, plus a space on a word gap. It sits between the key synchroniser and the character sink (display/UART). It replaces the one-symbol-per-clock letter FSM with real timing, a wider alphabet, and error reporting.

Parameters:
DOT_MAX, 4, mark shorter than DOT_MAX cycles = dot; DOT_MAX or more = dash
LETTER_GAP, 8, consecutive low cycles after a mark that end a character
WORD_GAP, 20, consecutive low cycles after a mark that emit a space; must be > LETTER_GAP
MARK_TIMEOUT, 32, mark length (cycles) treated as a stuck key; must be > DOT_MAX
MAX_SYMBOLS, 5, symbols per character; minimum 5

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
key_in  in  1  1 = key down (mark), 0 = key up; already synchronised and debounced
char_out  out  8  ASCII of last decoded character; held between pulses
char_valid  out  1  one-cycle pulse, char_out is new
error  out  1  one-cycle pulse, coincident with char_valid on bad code, or alone on timeout

Behaviour:
- Reset, synchronous and active-high: char_out=8'h00, char_valid=0, error=0, state=IDLE, pattern/len/counters cleared, space_armed=0. A reset mid-character discards the partial symbols with no output.
- Symbol encoding: dot=0, dash=1. On each new symbol, pattern shifts left and the symbol enters the LSB; len counts symbols, 0..MAX_SYMBOLS.
- Counter: one shared saturating counter, width clog2(max(WORD_GAP, MARK_TIMEOUT))+1. It is loaded with 1 on the first cycle of each mark or gap.
- State IDLE (no character in progress):
  - key_in=1 → MARK, cnt=1.
  - Otherwise count low cycles. If space_armed and cnt reaches WORD_GAP → emit 0x20 and clear space_armed. This happens once per gap.
- State MARK:
  - key_in=1 → cnt++.
  - If cnt reaches MARK_TIMEOUT → error pulse, clear pattern/len, go to HOLD.
  - key_in=0 → classify (cnt<DOT_MAX: dot, else dash), append the symbol, go to GAP with cnt=1.
  - If len was already MAX_SYMBOLS, do not append; set the sticky overflow flag instead.
- State GAP:
  - key_in=1 before cnt reaches LETTER_GAP → MARK (intra-character gap).
  - When cnt reaches LETTER_GAP → emit the character, set space_armed, go to IDLE. Counting continues, so the word gap is measured from the end of the last mark.
- State HOLD: wait for key_in=0, then go to IDLE. space_armed is unchanged.
- Emit timing:
  - char_valid=1 for exactly one cycle, beginning at the clock edge that samples the LETTER_GAP-th consecutive low key_in (or the WORD_GAP-th for a space).
  - char_out updates on the same edge.
  - pattern, len and overflow clear on emit.
- Lookup: (len, pattern) → ASCII for A–Z (0x41–0x5A) and 0–9 (0x30–0x39), ITU codes. Any unmapped code or overflow → char_out=0x3F ('?') with error=1 in the same cycle.
- No emit occurs with len=0. A space never appears before the first character after reset, and never twice in a row.
- Simultaneous events: reset overrides everything. Emit and a new key press cannot coincide, because a key press before LETTER_GAP keeps the character open.

Decomposition:
- Shared package morse_pkg:
  - state enum: IDLE, MARK, GAP, HOLD
  - ASCII constants: SPACE=0x20, UNKNOWN=0x3F
  - symbol constants: DOT=0, DASH=1
- Sub-module morse_lut: purely combinational. Inputs len[2:0] and pattern[MAX_SYMBOLS-1:0]; outputs ascii[7:0] and hit. Shared with the future encoder block.

Test Plan:
All scenarios use the parameter defaults (DOT_MAX=4, LETTER_GAP=8, WORD_GAP=20, MARK_TIMEOUT=32).
1. key high 2 cycles, then low 8 → char_valid pulse on the 8th low cycle, char_out=0x45 ('E'), error=0.
2. marks 6,2,6,2 cycles separated by 2-cycle gaps, then low 8 → 0x43 ('C'); repeat with marks 3 vs 4 cycles to confirm the dot/dash boundary.
3. five 6-cycle dashes → 0x30 ('0'); hold low to 20 cycles after the last mark → one extra pulse with 0x20; 50 further low cycles → no more pulses.
4. six dots → 0x3F with error=1. Then the unmapped pattern dot-dot-dash-dash → 0x3F with error=1.
5. key high 32 cycles → error pulse with char_valid=0; release, then a 2-cycle dot and low 8 → 'E'.
6. two dots, then reset for 1 cycle during the gap → no output. Then a 6-cycle mark and low 8 → 0x54 ('T'), and no space emitted first.
